mem_port_arb: RTL and testbench

- Two-requester, one-port memory arbiter that shares a single memory bus between the instruction fetch path and the load/store unit.
- The fetch requester is the memory-side port of the instruction fetch channel; the LSU is the data requester.
- Round-robin arbitration with grant lock while a request is stalled.
- Responses are returned in order and routed to the issuing requester through an ordered owner FIFO.
- Sits between the core front/back end and the bus/cache interface.

---
 rtl/mem_port_arb.sv | 138 +++++++++++++
 tb/tb_mem_port_arb.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Two-requester round-robin arbiter sharing one memory port between fetch (IFU) and LSU.
// Responses return in order and are steered by an owner FIFO; only state is registered.
module mem_port_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OUTST  = 2
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_vld,
    output logic                ifu_req_rdy,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_vld,
    input  logic                ifu_rsp_rdy,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,

    input  logic                lsu_req_vld,
    output logic                lsu_req_rdy,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_we,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_rsp_vld,
    input  logic                lsu_rsp_rdy,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,

    output logic                mem_req_vld,
    input  logic                mem_req_rdy,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_vld,
    output logic                mem_rsp_rdy,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err
);

    localparam int CNT_W = $clog2(OUTST + 1);
    localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTST - 1);

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

    req_id_t          last_grant;
    req_id_t          lock_owner;
    req_id_t          grant;
    req_id_t          head;
    req_id_t          owner_mem [OUTST];
    logic             lock;
    logic             rst_q;
    logic             active;
    logic             not_full;
    logic             empty;
    logic             gnt_vld;
    logic             req_hs;
    logic             rsp_hs;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshakes are suppressed in the reset cycle and the one after it.
    always_comb begin
        active   = !rst && !rst_q;
        not_full = count < FULL_CNT;
        empty    = count == '0;
        head     = owner_mem[rd_ptr];

        grant = REQ_IFU;
        if (lock)
            grant = lock_owner;
        else if (ifu_req_vld && lsu_req_vld)
            grant = (last_grant == REQ_IFU) ? REQ_LSU : REQ_IFU;
        else if (lsu_req_vld)
            grant = REQ_LSU;

        gnt_vld       = (grant == REQ_LSU) ? lsu_req_vld : ifu_req_vld;
        mem_req_vld   = active && gnt_vld && not_full;
        ifu_req_rdy   = active && (grant == REQ_IFU) && not_full && mem_req_rdy;
        lsu_req_rdy   = active && (grant == REQ_LSU) && not_full && mem_req_rdy;
        mem_req_addr  = (grant == REQ_LSU) ? lsu_req_addr : ifu_req_addr;
        mem_req_we    = (grant == REQ_LSU) && lsu_req_we;
        mem_req_wdata = (grant == REQ_LSU) ? lsu_req_wdata : '0;
        mem_req_wstrb = (grant == REQ_LSU) ? lsu_req_wstrb : '0;

        ifu_rsp_vld  = active && !empty && (head == REQ_IFU) && mem_rsp_vld;
        lsu_rsp_vld  = active && !empty && (head == REQ_LSU) && mem_rsp_vld;
        mem_rsp_rdy  = active && !empty && ((head == REQ_LSU) ? lsu_rsp_rdy : ifu_rsp_rdy);
        ifu_rsp_data = mem_rsp_data;
        lsu_rsp_data = mem_rsp_data;
        ifu_rsp_err  = mem_rsp_err;
        lsu_rsp_err  = mem_rsp_err;

        req_hs = mem_req_vld && mem_req_rdy;
        rsp_hs = mem_rsp_vld && mem_rsp_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q      <= 1'b1;
            last_grant <= REQ_IFU;
            lock_owner <= REQ_IFU;
            lock       <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            rst_q <= 1'b0;
            if (req_hs) begin
                owner_mem[wr_ptr] <= grant;
                wr_ptr            <= ptr_next(wr_ptr);
                last_grant        <= grant;
                lock              <= 1'b0;
            end else if (mem_req_vld) begin
                lock       <= 1'b1;
                lock_owner <= grant;
            end
            if (rsp_hs)
                rd_ptr <= ptr_next(rd_ptr);
            if (req_hs && !rsp_hs)
                count <= count + 1'b1;
            else if (!req_hs && rsp_hs)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: random requesters and an in-order memory model,
// checked against a queue-based reference of the arbitration and routing rules.
module tb_mem_port_arb;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int OUTST  = 2;
    localparam int SW     = DATA_W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              ifu_req_vld, ifu_req_rdy, ifu_rsp_vld, ifu_rsp_rdy, ifu_rsp_err;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic [DATA_W-1:0] ifu_rsp_data;
    logic              lsu_req_vld, lsu_req_rdy, lsu_req_we, lsu_rsp_vld, lsu_rsp_rdy, lsu_rsp_err;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic [DATA_W-1:0] lsu_req_wdata, lsu_rsp_data;
    logic [SW-1:0]     lsu_req_wstrb;
    logic              mem_req_vld, mem_req_rdy, mem_req_we, mem_rsp_vld, mem_rsp_rdy, mem_rsp_err;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata, mem_rsp_data;
    logic [SW-1:0]     mem_req_wstrb;

    mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTST(OUTST)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_vld(ifu_req_vld), .ifu_req_rdy(ifu_req_rdy), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_vld(ifu_rsp_vld), .ifu_rsp_rdy(ifu_rsp_rdy), .ifu_rsp_data(ifu_rsp_data),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_vld(lsu_req_vld), .lsu_req_rdy(lsu_req_rdy), .lsu_req_addr(lsu_req_addr),
        .lsu_req_we(lsu_req_we), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_vld(lsu_rsp_vld), .lsu_rsp_rdy(lsu_rsp_rdy), .lsu_rsp_data(lsu_rsp_data),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_err(mem_rsp_err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [SW-1:0]     wstrb;
    } req_t;

    typedef struct packed {
        logic              own;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: owner 0 = IFU, 1 = LSU.
    req_t exp_ifu[$];
    req_t exp_lsu[$];
    rsp_t exp_rsp[$];
    bit   mem_owner_q[$];
    bit   m_fifo[$];
    bit   grant_log[$];

    int   m_count;
    bit   m_last, m_lock, m_lock_own, m_guard;
    bit   ifu_hs_f, lsu_hs_f, rsp_hs_f;

    bit   want_rst = 1'b1;
    bit   holdoff = 1'b1;
    bit   presenting = 1'b0;
    int   ifu_left = 0, lsu_left = 0;
    int   ifu_rate = 100, lsu_rate = 100, mem_rdy_rate = 100, rsp_rate = 100;
    int   ifu_rr_rate = 100, lsu_rr_rate = 100;
    logic [ADDR_W-1:0] ifu_next_addr = '0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Stimulus: requesters and memory, all driven 1 time unit after the rising edge.
    initial begin
        req_t r;
        rsp_t p;
        rst = 1'b1;
        ifu_req_vld = 0; ifu_req_addr = '0; ifu_rsp_rdy = 0;
        lsu_req_vld = 0; lsu_req_addr = '0; lsu_req_we = 0; lsu_req_wdata = '0;
        lsu_req_wstrb = '0; lsu_rsp_rdy = 0;
        mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_data = '0; mem_rsp_err = 0;
        forever begin
            @(posedge clk);
            #1;
            rst = want_rst;
            if (want_rst) begin
                ifu_req_vld = 0; lsu_req_vld = 0;
                ifu_left = 0; lsu_left = 0;
                exp_ifu.delete(); exp_lsu.delete(); exp_rsp.delete(); mem_owner_q.delete();
                mem_req_rdy = 1; ifu_rsp_rdy = 1; lsu_rsp_rdy = 1;
                mem_rsp_vld = 1; mem_rsp_data = $urandom; mem_rsp_err = 1;
                presenting = 0;
            end else begin
                if (ifu_req_vld && ifu_hs_f) ifu_req_vld = 0;
                if (!ifu_req_vld && ifu_left > 0 && $urandom_range(0, 99) < ifu_rate) begin
                    r = '0;
                    r.addr = ifu_next_addr;
                    ifu_next_addr += 4;
                    ifu_left--;
                    ifu_req_vld = 1; ifu_req_addr = r.addr;
                    exp_ifu.push_back(r);
                end
                if (lsu_req_vld && lsu_hs_f) lsu_req_vld = 0;
                if (!lsu_req_vld && lsu_left > 0 && $urandom_range(0, 99) < lsu_rate) begin
                    r.addr  = $urandom;
                    r.we    = 1'($urandom_range(0, 1));
                    r.wdata = $urandom;
                    r.wstrb = r.we ? SW'($urandom) : '0;
                    lsu_left--;
                    lsu_req_vld = 1; lsu_req_addr = r.addr; lsu_req_we = r.we;
                    lsu_req_wdata = r.wdata; lsu_req_wstrb = r.wstrb;
                    exp_lsu.push_back(r);
                end
                mem_req_rdy = $urandom_range(0, 99) < mem_rdy_rate;
                ifu_rsp_rdy = $urandom_range(0, 99) < ifu_rr_rate;
                lsu_rsp_rdy = $urandom_range(0, 99) < lsu_rr_rate;
                if (holdoff) begin
                    mem_rsp_vld = 1; mem_rsp_err = 1; presenting = 0;
                end else begin
                    if (mem_rsp_vld && (!presenting || rsp_hs_f)) begin
                        mem_rsp_vld = 0; presenting = 0;
                    end
                    if (!mem_rsp_vld && mem_owner_q.size() > 0 && $urandom_range(0, 99) < rsp_rate) begin
                        p.own  = mem_owner_q.pop_front();
                        p.err  = 1'($urandom_range(0, 3) == 0);
                        p.data = $urandom;
                        mem_rsp_vld = 1; mem_rsp_data = p.data; mem_rsp_err = p.err;
                        presenting = 1;
                        exp_rsp.push_back(p);
                    end
                end
            end
        end
    end

    // Monitor and reference model, evaluated on the falling edge.
    initial begin
        bit ivld, lvld, pown, pvld, h, req_hs, rsp_hs;
        req_t er;
        rsp_t got;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_outputs", {ifu_req_rdy, lsu_req_rdy, mem_req_vld, mem_rsp_rdy, ifu_rsp_vld, lsu_rsp_vld}, '0);
                m_count = 0; m_last = 0; m_lock = 0; m_guard = 1;
                m_fifo.delete();
                ifu_hs_f = 0; lsu_hs_f = 0; rsp_hs_f = 0;
            end else if (m_guard) begin
                chk("post_rst_outputs", {ifu_req_rdy, lsu_req_rdy, mem_req_vld, mem_rsp_rdy, ifu_rsp_vld, lsu_rsp_vld}, '0);
                m_guard = 0;
                ifu_hs_f = 0; lsu_hs_f = 0; rsp_hs_f = 0;
            end else begin
                rsp_hs = 0;
                if (m_fifo.size() == 0) begin
                    chk("rsp_idle", {mem_rsp_rdy, ifu_rsp_vld, lsu_rsp_vld}, '0);
                end else begin
                    h = m_fifo[0];
                    chk("rsp_route", {ifu_rsp_vld, lsu_rsp_vld, mem_rsp_rdy},
                        {mem_rsp_vld && !h, mem_rsp_vld && h, h ? lsu_rsp_rdy : ifu_rsp_rdy});
                    rsp_hs = mem_rsp_vld && (h ? lsu_rsp_rdy : ifu_rsp_rdy);
                end
                if ((ifu_rsp_vld && ifu_rsp_rdy) || (lsu_rsp_vld && lsu_rsp_rdy)) begin
                    got.own  = lsu_rsp_vld;
                    got.err  = lsu_rsp_vld ? lsu_rsp_err : ifu_rsp_err;
                    got.data = lsu_rsp_vld ? lsu_rsp_data : ifu_rsp_data;
                    if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
                    else chk("rsp_data", got, exp_rsp.pop_front());
                end
                if (rsp_hs) void'(m_fifo.pop_front());

                ivld = ifu_req_vld;
                lvld = lsu_req_vld;
                if (m_lock) pown = m_lock_own;
                else if (ivld && lvld) pown = !m_last;
                else pown = lvld;
                pvld = (pown ? lvld : ivld) && (m_count < OUTST);
                req_hs = 0;
                chk("mem_req_vld", mem_req_vld, pvld);
                if (pvld) begin
                    chk("req_rdy", {ifu_req_rdy, lsu_req_rdy}, {!pown && mem_req_rdy, pown && mem_req_rdy});
                    if ((pown ? exp_lsu.size() : exp_ifu.size()) == 0) begin
                        chk("req_queue", 0, 1);
                    end else begin
                        er = pown ? exp_lsu[0] : exp_ifu[0];
                        chk("mem_req_payload", {mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb}, er);
                    end
                    if (mem_req_rdy) begin
                        req_hs = 1;
                        if (pown) void'(exp_lsu.pop_front()); else void'(exp_ifu.pop_front());
                        m_fifo.push_back(pown);
                        mem_owner_q.push_back(pown);
                        grant_log.push_back(pown);
                        m_last = pown;
                        m_lock = 0;
                    end else begin
                        m_lock = 1;
                        m_lock_own = pown;
                    end
                end else begin
                    chk("no_req_hs", {ivld && ifu_req_rdy, lvld && lsu_req_rdy}, '0);
                end
                m_count = m_count + int'(req_hs) - int'(rsp_hs);
                ifu_hs_f = ifu_req_vld && ifu_req_rdy;
                lsu_hs_f = lsu_req_vld && lsu_req_rdy;
                rsp_hs_f = mem_rsp_vld && mem_rsp_rdy;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (n < 1000 && (ifu_left > 0 || lsu_left > 0 || ifu_req_vld || lsu_req_vld ||
                            m_fifo.size() > 0 || mem_rsp_vld)) begin
            cycles(1);
            n++;
        end
        chk({name, "_drain"}, n < 1000, 1);
    endtask

    task automatic do_reset();
        want_rst = 1; holdoff = 1;
        cycles(1);
        want_rst = 0;
        cycles(4);
        chk("holdoff_mem_rsp_rdy", {mem_rsp_vld, mem_rsp_rdy, ifu_rsp_vld, lsu_rsp_vld}, 4'b1000);
        holdoff = 0;
        cycles(2);
    endtask

    initial begin
        cycles(3);
        want_rst = 0;
        cycles(4);
        chk("holdoff_initial", {mem_rsp_vld, mem_rsp_rdy}, 2'b10);
        holdoff = 0;
        cycles(2);

        // IFU-only sequential fetches 0x0, 0x4, 0x8.
        grant_log.delete();
        ifu_left = 3;
        drain("ifu_only");
        chk("ifu_only_grants", {32'(grant_log.size()), grant_log.size() == 3 ? {grant_log[0], grant_log[1], grant_log[2]} : 3'b111}, {32'd3, 3'b000});

        // Both requesting continuously: strict alternation starting with LSU.
        do_reset();
        grant_log.delete();
        ifu_left = 10; lsu_left = 10;
        drain("rr");
        chk("rr_count", grant_log.size(), 20);
        for (int i = 0; i < 20 && i < grant_log.size(); i++)
            chk("rr_order", grant_log[i], (i % 2) == 0);

        // IFU stalled by memory while LSU arrives: grant stays locked on IFU.
        grant_log.delete();
        mem_rdy_rate = 0;
        ifu_left = 1;
        cycles(2);
        lsu_left = 1;
        cycles(3);
        chk("lock_addr", mem_req_addr, exp_ifu.size() > 0 ? exp_ifu[0].addr : '1);
        chk("lock_lsu_rdy", {mem_req_vld, lsu_req_vld, lsu_req_rdy}, 3'b110);
        mem_rdy_rate = 100;
        drain("lock");
        chk("lock_order", {32'(grant_log.size()), grant_log.size() == 2 ? {grant_log[0], grant_log[1]} : 2'b11}, {32'd2, 2'b01});

        // Fill to OUTST with no responses, then release.
        rsp_rate = 0;
        ifu_left = 3; lsu_left = 3;
        cycles(10);
        chk("full_blocks", {mem_req_vld, ifu_req_rdy, lsu_req_rdy}, 3'b000);
        chk("full_pending", ifu_req_vld || lsu_req_vld, 1);
        rsp_rate = 100;
        drain("full");

        // Response stalled at the requester side.
        lsu_rr_rate = 30; ifu_rr_rate = 30;
        lsu_left = 4; ifu_left = 4;
        drain("rsp_stall");
        lsu_rr_rate = 100; ifu_rr_rate = 100;

        // Random traffic.
        ifu_rate = 50; lsu_rate = 50; mem_rdy_rate = 60; rsp_rate = 60;
        ifu_rr_rate = 70; lsu_rr_rate = 70;
        ifu_left = 60; lsu_left = 60;
        drain("random");

        // Reset with two transactions in flight; then LSU wins first contention.
        ifu_rate = 100; lsu_rate = 100; mem_rdy_rate = 100; rsp_rate = 0;
        ifu_rr_rate = 100; lsu_rr_rate = 100;
        ifu_left = 2; lsu_left = 2;
        cycles(8);
        chk("pre_rst_full", mem_req_vld, 0);
        do_reset();
        rsp_rate = 100;
        grant_log.delete();
        ifu_left = 2; lsu_left = 2;
        drain("post_rst");
        chk("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
